// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor computing a - b - bin_init over WIDTH clock
// cycles, LSB first. It uses one full-subtracter cell and a borrow flop.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request pulse, sampled only while idle
//   a, b       in   [WIDTH-1:0] minuend / subtrahend, captured on the accepted start
//   bin_init   in   initial borrow-in, captured on the accepted start
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse; difference/bout are valid then and held afterwards
//   difference out  [WIDTH-1:0] (a - b - bin_init) mod 2^WIDTH
//   bout       out  final borrow, 1 iff a < b + bin_init (unsigned)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             bout
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic            borrow;
    logic [CntW-1:0] cnt;

    // Full-subtracter cell operating on the current LSBs.
    logic diff_bit;
    logic bout_cell;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        diff_bit  = a_sh[0] ^ b_sh[0] ^ borrow;
        bout_cell = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        // The result fills from the MSB side, so after WIDTH shifts bit 0 sits at the LSB.
        res_next  = {diff_bit, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            bout       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        borrow  <= bin_init;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= bout_cell;
                    if (cnt == LastBit) begin
                        // Final bit: publish the completed result together with done.
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        difference <= res_next;
                        bout       <= bout_cell;
                        state_q    <= StDone;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial multi-bit subtractor built around one full_subtracter cell plus a borrow flip-flop. It computes a - b - bin_init LSB-first over WIDTH clock cycles and uses start/busy/done handshaking. It is the next stage above the single-bit full subtracter and reuses that cell for every bit, trading latency for area.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start
b  input  WIDTH  subtrahend; captured on the accepted start
bin_init  input  1  initial borrow-in; captured on the accepted start
busy  output  1  high while an operation is in progress (SHIFT state)
done  output  1  one-cycle pulse when the result is valid
difference  output  WIDTH  registered result, (a - b - bin_init) mod 2^WIDTH
bout  output  1  final borrow-out; 1 iff a < b + bin_init (unsigned)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, difference=0, bout=0; internal shift registers, borrow flop and bit counter are cleared. Reset has priority over all other inputs.
- FSM states and transitions:
  - IDLE: busy=0, done=0. If start=1, load a_sh<=a, b_sh<=b, borrow<=bin_init, cnt<=0, then go to SHIFT. Otherwise remain in IDLE.
  - SHIFT: busy=1. Each cycle, the full_subtracter takes a_sh[0], b_sh[0] and borrow. Its difference bit shifts into the MSB of the result shift register. a_sh and b_sh shift right by 1. borrow<=bout_cell, cnt<=cnt+1. When cnt==WIDTH-1, this is the last bit: go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. The difference output is loaded from the result shift register and bout from the borrow flop on entry to DONE, so both are valid while done=1. The next state is always IDLE.
- Latency: start accepted at edge N; busy is high for cycles N+1..N+WIDTH; done=1 in cycle N+WIDTH+1; the next start is accepted at the earliest at edge N+WIDTH+2.
- difference and bout hold their previous result during SHIFT and after done. They change only on entry to DONE or on reset.
- start while busy, or in DONE, is ignored. It is not queued, and operands on a/b at that time are not sampled.
- Operands a, b and bin_init may change freely after the accepting edge without affecting the operation in progress.
- Reset asserted mid-operation aborts it: no done pulse is produced, and outputs return to 0.
- The counter must be wide enough for WIDTH-1, computed as clog2(WIDTH) bits. No wrap-around occurs beyond that value.
- Arithmetic: {bout, difference} equals the WIDTH+1-bit two's-complement result of a - b - bin_init. bin_init=1 with a=b yields all ones and bout=1.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h23, bin_init=0, start pulse at edge N -> busy high for 8 cycles; done=1 at cycle N+9; difference=8'h37, bout=0.
- a=8'h10, b=8'h20, bin_init=0 -> difference=8'hF0, bout=1. Then a=8'h00, b=8'h00, bin_init=1 -> difference=8'hFF, bout=1.
- a=8'hFF, b=8'hFF, bin_init=1 -> difference=8'hFF, bout=1. Back-to-back start issued the cycle after done -> accepted; second result correct.
- Pulse start=1 with a=8'h01 at cycle N+3 of a running 8'h5A-8'h23 operation -> ignored; result is still 8'h37 and done fires only once.
- Assert rst at cycle N+4 of an operation -> busy=0, done never pulses, difference=0, bout=0. A new start afterwards completes normally.
- WIDTH=4, exhaustive a,b in 0..15, bin_init in {0,1} -> every result matches {bout,difference} = a - b - bin_init (5-bit), and done arrives exactly 5 cycles after each accepted start.
